// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: cycle-by-cycle control and EXE stall for the multi-cycle RV32M multiply/divide path.
module muldiv_sequencer #(
  parameter int DIV_ITERS = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_i,
  input  logic       is_div_i,
  input  logic       flush_i,
  input  logic       hold_i,
  output logic [1:0] mul_state_o,
  output logic       mul_en_o,
  output logic       d_init_o,
  output logic       d_advance_o,
  output logic       div_last_o,
  output logic       stall_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  localparam logic [5:0] LAST = 6'(DIV_ITERS);
  state_e     state_q;
  logic [1:0] mc_q;
  logic [5:0] dc_q;
  logic       busy_q;
  logic       run, idle_go, in_mul, in_div, mul_done, div_done;
  assign run      = !flush_i && !hold_i;
  assign in_mul   = state_q == MUL;
  assign in_div   = state_q == DIV;
  assign idle_go  = state_q == IDLE && start_i && run;
  assign mul_done = in_mul && mc_q == 2'd3;
  assign div_done = in_div && dc_q == LAST;
  assign mul_state_o = in_mul ? mc_q : 2'd0;
  assign mul_en_o    = (idle_go && !is_div_i) || (run && in_mul);
  assign d_init_o    = idle_go && is_div_i;
  assign d_advance_o = run && in_div;
  // the final divide cycle keeps flagging the result even while frozen
  assign div_last_o  = !flush_i && div_done;
  assign stall_o     = !flush_i && (idle_go || (in_mul && !mul_done) || (in_div && !div_done));
  assign busy_o      = busy_q;
  always_ff @(posedge clk) begin
    if (!resetn || flush_i) begin
      state_q <= IDLE;
      mc_q    <= 2'd0;
      dc_q    <= 6'd0;
      busy_q  <= 1'b0;
    end else if (!hold_i) begin
      if (state_q == IDLE && start_i) begin
        state_q <= is_div_i ? DIV : MUL;
        mc_q    <= is_div_i ? 2'd0 : 2'd1;
        dc_q    <= is_div_i ? 6'd1 : 6'd0;
        busy_q  <= 1'b1;
      end else if (mul_done || div_done) begin
        state_q <= IDLE;
        mc_q    <= 2'd0;
        dc_q    <= 6'd0;
        busy_q  <= 1'b0;
      end else begin
        mc_q <= mc_q + 2'(in_mul);
        dc_q <= dc_q + 6'(in_div);
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed per-cycle checks of the multiply/divide sequencer outputs.
module tb_muldiv_sequencer;
  logic       clk = 1'b0;
  logic       resetn, start_i, is_div_i, flush_i, hold_i;
  logic [1:0] mul_state_o;
  logic       mul_en_o, d_init_o, d_advance_o, div_last_o, stall_o, busy_o;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  muldiv_sequencer #(.DIV_ITERS(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .is_div_i(is_div_i),
    .flush_i(flush_i), .hold_i(hold_i), .mul_state_o(mul_state_o), .mul_en_o(mul_en_o),
    .d_init_o(d_init_o), .d_advance_o(d_advance_o), .div_last_o(div_last_o),
    .stall_o(stall_o), .busy_o(busy_o)
  );
  function automatic logic [7:0] pk(input logic busy, stall, last, adv, init, en, input logic [1:0] ms);
    return {busy, stall, last, adv, init, en, ms};
  endfunction
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,stall,last,adv,init,en,ms)", tag, got, exp);
    end
  endtask
  // sample mid-cycle, then move to just after the next rising edge
  task automatic at(input string tag, input logic [7:0] exp);
    #4;
    check(tag, {busy_o, stall_o, div_last_o, d_advance_o, d_init_o, mul_en_o, mul_state_o}, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    resetn = 1'b0; start_i = 1'b0; is_div_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    at("reset", pk(0, 0, 0, 0, 0, 0, 2'd0));
    start_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) start_i = 1'b0;
      at("mul", pk(c != 0, c != 3, 0, 0, 0, 1, 2'(c)));
    end
    at("mul_idle", pk(0, 0, 0, 0, 0, 0, 2'd0));
    start_i = 1'b1; is_div_i = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      if (c == 32) start_i = 1'b0;
      at("div", pk(c != 0, c != 32, c == 32, c != 0, c == 0, 0, 2'd0));
    end
    at("div_idle", pk(0, 0, 0, 0, 0, 0, 2'd0));
    start_i = 1'b1; is_div_i = 1'b0;
    for (int c = 0; c <= 36; c++) begin
      if (c == 4) is_div_i = 1'b1;
      if (c == 36) start_i = 1'b0;
      if (c < 4) at("b2b_mul", pk(c != 0, c != 3, 0, 0, 0, 1, 2'(c)));
      else at("b2b_div", pk(c != 4, c != 36, c == 36, c != 4, c == 4, 0, 2'd0));
    end
    at("b2b_idle", pk(0, 0, 0, 0, 0, 0, 2'd0));
    start_i = 1'b1; is_div_i = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      hold_i = (c == 10 || c == 11);
      if (c == 34) start_i = 1'b0;
      if (c == 0) at("hold_div", pk(0, 1, 0, 0, 1, 0, 2'd0));
      else at("hold_div", pk(1, c != 34, c == 34, !hold_i, 0, 0, 2'd0));
    end
    hold_i = 1'b0;
    at("hold_idle", pk(0, 0, 0, 0, 0, 0, 2'd0));
    start_i = 1'b1; is_div_i = 1'b1;
    for (int c = 0; c < 5; c++) at("pre_flush", pk(c != 0, 1, 0, c != 0, c == 0, 0, 2'd0));
    flush_i = 1'b1;
    at("flush", pk(1, 0, 0, 0, 0, 0, 2'd0));
    flush_i = 1'b0; is_div_i = 1'b0;
    at("post_flush", pk(0, 1, 0, 0, 0, 1, 2'd0));
    at("mul_mc1", pk(1, 1, 0, 0, 0, 1, 2'd1));
    resetn = 1'b0;
    #4;
    @(posedge clk);
    #1;
    resetn = 1'b1; start_i = 1'b0;
    at("mid_reset", pk(0, 0, 0, 0, 0, 0, 2'd0));
    start_i = 1'b1; hold_i = 1'b1;
    at("idle_hold", pk(0, 0, 0, 0, 0, 0, 2'd0));
    hold_i = 1'b0; flush_i = 1'b1;
    at("idle_flush", pk(0, 0, 0, 0, 0, 0, 2'd0));
    flush_i = 1'b0;
    for (int c = 0; c < 3; c++) at("late_mul", pk(c != 0, 1, 0, 0, 0, 1, 2'(c)));
    hold_i = 1'b1;
    at("mul3_hold", pk(1, 0, 0, 0, 0, 0, 2'd3));
    hold_i = 1'b0; start_i = 1'b0;
    at("mul3", pk(1, 0, 0, 0, 0, 1, 2'd3));
    at("end_idle", pk(0, 0, 0, 0, 0, 0, 2'd0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multi-cycle RV32M multiply/divide path inside the EXE-stage ALU. It decodes a start request for a MUL-class or DIV-class op and drives the ALU's `mul_state`, `d_init`, `d_advance` and `div_last` controls cycle by cycle. It also asserts a stall request to the hazard unit so the EXE stage holds the instruction until the result is final. It sits beside the ALU in EXE, fed from ID-stage decode, and its stall output feeds the hazard unit's EXE stall.

## Interface
- DIV_ITERS, default 32, number of radix-2 division iterations (d_advance cycles); legal range 2..63.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start_i  in  1  EXE holds a valid M-extension op; held stable by the pipeline while stall_o=1.
- is_div_i  in  1  1 = DIV/DIVU/REM/REMU, 0 = MUL/MULH/MULHSU/MULHU; sampled only with start_i.
- flush_i  in  1  EXE flush; aborts any op in progress.
- hold_i  in  1  external freeze (MEM-side stall); sequencer state frozen.
- mul_state_o  out  2  partial-product select for ALU multiplier (0..3).
- mul_en_o  out  1  multiplier accumulate enable this cycle.
- d_init_o  out  1  divider register load strobe.
- d_advance_o  out  1  divider one-iteration strobe.
- div_last_o  out  1  final divider iteration; ALU result is valid.
- stall_o  out  1  request to hold IF/ID/EXE; result not yet final.
- busy_o  out  1  registered; sequencer in MUL or DIV state.

## Operation
- States: IDLE, MUL, DIV. 2-bit mul counter `mc`, 6-bit div counter `dc`.
- IDLE, start_i=1, flush_i=0, hold_i=0:
  - mul: mul_state_o=0, mul_en_o=1, stall_o=1; next MUL with mc=1.
  - div: d_init_o=1, stall_o=1; next DIV with dc=1.
- MUL: mul_state_o=mc, mul_en_o=1.
  - mc<3: stall_o=1, mc++.
  - mc=3: stall_o=0; next IDLE.
- DIV: d_advance_o=1.
  - dc<DIV_ITERS: stall_o=1, dc++.
  - dc=DIV_ITERS: div_last_o=1, stall_o=0; next IDLE.
- Outputs are combinational from state, counters and start_i/is_div_i/hold_i/flush_i. start_i is recognised in the same cycle it rises.
- Back-to-back: in the final cycle stall_o=0 and the pipeline advances. If start_i=1 in the following IDLE cycle, a new op begins. The final cycle never re-samples start_i.
- flush_i=1 (any state, including simultaneous with start_i): all strobes and stall_o are 0 that cycle; next state IDLE with counters cleared. flush_i has priority over hold_i.
- hold_i=1, no flush: state and counters frozen.
  - mul_en_o, d_init_o and d_advance_o are forced to 0.
  - mul_state_o, div_last_o and stall_o show their unfrozen values. In the final cycle under hold_i, stall_o=0 and div_last_o is still shown.
  - In IDLE, start_i is ignored.
- mul_state_o is 0 outside MUL/IDLE-start. No strobe is ever active in IDLE without start_i.

## Timing
- Reset (resetn=0 at clk edge): state IDLE, mc=0, dc=0, busy_o=0. All combinational outputs are 0 while the registers hold reset values and start_i=0.
- MUL latency: 4 cycles from start_i, with stall_o=1 for 3 cycles. Result is valid in the 4th cycle (mul_state_o=3).
- DIV latency: DIV_ITERS+1 cycles (33 by default), with stall_o=1 for DIV_ITERS cycles. Result is valid in the cycle with div_last_o=1.
- Each cycle with hold_i=1 extends latency by exactly one cycle.
- busy_o is high from the cycle after start until the cycle after the final cycle (exclusive).
- resetn=0 mid-op returns to IDLE at that edge, same as flush.

## Test plan
- MUL start, no hold -> mul_state_o 0,1,2,3 on cycles 0..3, mul_en_o=1 throughout, stall_o 1,1,1,0, then IDLE.
- DIV start, DIV_ITERS=32 -> d_init_o on cycle 0; d_advance_o on cycles 1..32; div_last_o only on cycle 32; stall_o=1 on cycles 0..31, 0 on cycle 32.
- Back-to-back MUL then DIV (start_i stays 1, is_div_i flips after MUL cycle 3) -> DIV d_init_o on cycle 4, div_last_o on cycle 36.
- hold_i=1 for 2 cycles at DIV dc=10 -> d_advance_o=0 for those cycles, dc frozen, div_last_o delayed to cycle 34.
- flush_i at DIV dc=5 -> strobes and stall_o 0 that cycle, busy_o=0 next cycle; a new MUL start next cycle shows mul_state_o=0.
- resetn low at MUL mc=2 -> next cycle all outputs 0, busy_o=0.
